// File: rtl/uart_pkg.sv
// Shared UART definitions: parity modes, receiver FSM encoding
// and the baud divisor helper. Intended for reuse by the transmitter.
package uart_pkg;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BRK_WAIT
    } rx_state_t;

    // Rounded clock-cycles-per-bit.
    function automatic int calc_div(input int clk_hz, input int baud);
        return (clk_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// First-word-fall-through FIFO for received frames.
// Ports: clk, rst_n, push/wdata in, pop in, rdata/full/empty out.
module uart_rx_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_pop  = pop && !empty;
    // A pop in the same cycle frees the slot a full FIFO needs.
    assign do_push = push && (!full || do_pop);
    // Gated so the head reads zero while nothing is stored.
    assign rdata   = empty ? '0 : mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst_n && do_push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: synchroniser, 3-sample majority voter,
// frame FSM with parity/framing/break detection, and an output FIFO.
// Ports: clk, rst_n, sci_rx, en_rx in; rx_data/rx_perr/rx_ferr/rx_valid
// out with rx_ready in; overrun, break_det pulses; busy out.
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_HZ     = 25000000,
    parameter int BAUD       = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 sci_rx,
    input  logic                 en_rx,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_perr,
    output logic                 rx_ferr,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 overrun,
    output logic                 break_det,
    output logic                 busy
);
    localparam int DIV  = calc_div(CLK_HZ, BAUD);
    localparam int HALF = DIV / 2;
    localparam int CW   = $clog2(DIV);
    localparam int BCW  = $clog2(DATA_BITS);
    localparam int FW   = DATA_BITS + 2;

    localparam logic [CW-1:0]  DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0]  HALF_M1 = CW'(HALF - 1);
    localparam logic [BCW-1:0] DATA_M1 = BCW'(DATA_BITS - 1);
    localparam logic [BCW-1:0] STOP_M1 = BCW'(STOP_BITS - 1);

    logic                 sync1;
    logic                 sync2;
    logic [2:0]           hist;
    logic                 smp;
    logic                 fall;
    rx_state_t            state;
    rx_state_t            state_n;
    logic [CW-1:0]        cnt;
    logic [CW-1:0]        cnt_n;
    logic [BCW-1:0]       bcnt;
    logic [BCW-1:0]       bcnt_n;
    logic [DATA_BITS-1:0] shreg;
    logic [DATA_BITS-1:0] shreg_n;
    logic                 perr;
    logic                 perr_n;
    logic                 ferr;
    logic                 ferr_n;
    logic                 par;
    logic                 par_n;
    logic                 ferr_fin;
    logic                 par_x;
    logic                 push;
    logic                 brk;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [FW-1:0]        fifo_rdata;

    assign smp  = (hist[0] & hist[1]) | (hist[0] & hist[2])
                | (hist[1] & hist[2]);
    // hist[0] holds last cycle's synchronised line.
    assign fall = hist[0] & ~sync2;
    assign busy = (state != ST_IDLE);

    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        bcnt_n   = bcnt;
        shreg_n  = shreg;
        perr_n   = perr;
        ferr_n   = ferr;
        par_n    = par;
        push     = 1'b0;
        brk      = 1'b0;
        ferr_fin = ferr | ~smp;
        par_x    = (^shreg) ^ smp;
        case (state)
            ST_IDLE: begin
                cnt_n  = '0;
                bcnt_n = '0;
                perr_n = 1'b0;
                ferr_n = 1'b0;
                par_n  = 1'b0;
                if (fall && en_rx) begin
                    state_n = ST_START;
                end
            end
            ST_START: begin
                if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    state_n = smp ? ST_IDLE : ST_DATA;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt == DIV_M1) begin
                    cnt_n   = '0;
                    shreg_n = {smp, shreg[DATA_BITS-1:1]};
                    if (bcnt == DATA_M1) begin
                        bcnt_n  = '0;
                        state_n = (PARITY != PAR_NONE) ? ST_PARITY
                                                       : ST_STOP;
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_PARITY: begin
                if (cnt == DIV_M1) begin
                    cnt_n   = '0;
                    par_n   = smp;
                    perr_n  = (PARITY == PAR_ODD) ? ~par_x : par_x;
                    state_n = ST_STOP;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt == DIV_M1) begin
                    cnt_n  = '0;
                    ferr_n = ferr_fin;
                    if (bcnt == STOP_M1) begin
                        bcnt_n = '0;
                        push   = 1'b1;
                        // Line low through data, parity and stop.
                        if (shreg == '0 && ferr_fin && !par) begin
                            brk     = 1'b1;
                            state_n = ST_BRK_WAIT;
                        end else begin
                            state_n = ST_IDLE;
                        end
                    end else begin
                        bcnt_n = bcnt + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            ST_BRK_WAIT: begin
                // Counts consecutive high cycles; any low restarts.
                if (!sync2) begin
                    cnt_n = '0;
                end else if (cnt == HALF_M1) begin
                    cnt_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = ST_IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1     <= 1'b1;
            sync2     <= 1'b1;
            hist      <= 3'b111;
            state     <= ST_IDLE;
            cnt       <= '0;
            bcnt      <= '0;
            shreg     <= '0;
            perr      <= 1'b0;
            ferr      <= 1'b0;
            par       <= 1'b0;
            overrun   <= 1'b0;
            break_det <= 1'b0;
        end else begin
            sync1     <= sci_rx;
            sync2     <= sync1;
            hist      <= {hist[1:0], sync2};
            state     <= state_n;
            cnt       <= cnt_n;
            bcnt      <= bcnt_n;
            shreg     <= shreg_n;
            perr      <= perr_n;
            ferr      <= ferr_n;
            par       <= par_n;
            // Full implies valid, so !rx_ready means no pop.
            overrun   <= push && fifo_full && !rx_ready;
            break_det <= brk;
        end
    end

    uart_rx_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .wdata ({shreg, perr, ferr_fin}),
        .pop   (rx_ready),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign rx_data  = fifo_rdata[FW-1:2];
    assign rx_perr  = fifo_rdata[1];
    assign rx_ferr  = fifo_rdata[0];
    assign rx_valid = ~fifo_empty;

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Testbench for uart_rx_cfg: default 8N1 instance (a), fast 8N1 (b)
// and fast 8E1 (c), with per-instance scoreboards of expected frames.
module tb_uart_rx_cfg;

    localparam int DIV_A  = 2604;
    localparam int HALF_A = 1302;
    localparam int DIV_F  = 16;
    localparam int HALF_F = 8;

    typedef logic [9:0] ent_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic en = 1'b1;
    int   cyc = 0;
    int   n_chk = 0;
    int   n_pass = 0;

    logic       a_rx = 1'b1, a_ready = 1'b1;
    logic [7:0] a_data;
    logic       a_perr, a_ferr, a_valid, a_ovr, a_brk, a_busy;
    logic       b_rx = 1'b1, b_ready = 1'b1;
    logic [7:0] b_data;
    logic       b_perr, b_ferr, b_valid, b_ovr, b_brk, b_busy;
    logic       c_rx = 1'b1, c_ready = 1'b1;
    logic [7:0] c_data;
    logic       c_perr, c_ferr, c_valid, c_ovr, c_brk, c_busy;

    ent_t q_a[$], q_b[$], q_c[$];
    ent_t e_a, e_b, e_c;
    int   a_nbrk = 0, a_novr = 0;
    int   b_nbrk = 0, b_novr = 0;
    int   c_nbrk = 0, c_novr = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx_cfg u_a (
        .clk(clk), .rst_n(rst_n), .sci_rx(a_rx), .en_rx(en),
        .rx_data(a_data), .rx_perr(a_perr), .rx_ferr(a_ferr),
        .rx_valid(a_valid), .rx_ready(a_ready), .overrun(a_ovr),
        .break_det(a_brk), .busy(a_busy)
    );

    uart_rx_cfg #(.CLK_HZ(1600000), .BAUD(100000)) u_b (
        .clk(clk), .rst_n(rst_n), .sci_rx(b_rx), .en_rx(en),
        .rx_data(b_data), .rx_perr(b_perr), .rx_ferr(b_ferr),
        .rx_valid(b_valid), .rx_ready(b_ready), .overrun(b_ovr),
        .break_det(b_brk), .busy(b_busy)
    );

    uart_rx_cfg #(.CLK_HZ(1600000), .BAUD(100000), .PARITY(2)) u_c (
        .clk(clk), .rst_n(rst_n), .sci_rx(c_rx), .en_rx(en),
        .rx_data(c_data), .rx_perr(c_perr), .rx_ferr(c_ferr),
        .rx_valid(c_valid), .rx_ready(c_ready), .overrun(c_ovr),
        .break_det(c_brk), .busy(c_busy)
    );

    // Scoreboard monitors: compare every accepted head entry.
    always @(negedge clk) begin
        if (a_valid && a_ready) begin
            n_chk++;
            if (q_a.size() == 0) begin
                $display("FAIL mon_a: unexpected entry %h",
                         {a_data, a_perr, a_ferr});
            end else begin
                e_a = q_a.pop_front();
                if ({a_data, a_perr, a_ferr} !== e_a)
                    $display("FAIL mon_a: got %h want %h",
                             {a_data, a_perr, a_ferr}, e_a);
                else n_pass++;
            end
        end
        if (a_brk) a_nbrk++;
        if (a_ovr) a_novr++;
    end

    always @(negedge clk) begin
        if (b_valid && b_ready) begin
            n_chk++;
            if (q_b.size() == 0) begin
                $display("FAIL mon_b: unexpected entry %h",
                         {b_data, b_perr, b_ferr});
            end else begin
                e_b = q_b.pop_front();
                if ({b_data, b_perr, b_ferr} !== e_b)
                    $display("FAIL mon_b: got %h want %h",
                             {b_data, b_perr, b_ferr}, e_b);
                else n_pass++;
            end
        end
        if (b_brk) b_nbrk++;
        if (b_ovr) b_novr++;
    end

    always @(negedge clk) begin
        if (c_valid && c_ready) begin
            n_chk++;
            if (q_c.size() == 0) begin
                $display("FAIL mon_c: unexpected entry %h",
                         {c_data, c_perr, c_ferr});
            end else begin
                e_c = q_c.pop_front();
                if ({c_data, c_perr, c_ferr} !== e_c)
                    $display("FAIL mon_c: got %h want %h",
                             {c_data, c_perr, c_ferr}, e_c);
                else n_pass++;
            end
        end
        if (c_brk) c_nbrk++;
        if (c_ovr) c_novr++;
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_line(input int w, input logic v);
        case (w)
            0:       a_rx = v;
            1:       b_rx = v;
            default: c_rx = v;
        endcase
    endtask

    task automatic send_frame(input int w, input int div,
                              input logic [7:0] d, input bit par_en,
                              input logic par_bit, input logic stop_bit);
        set_line(w, 1'b0);
        tick(div);
        for (int i = 0; i < 8; i++) begin
            set_line(w, d[i]);
            tick(div);
        end
        if (par_en) begin
            set_line(w, par_bit);
            tick(div);
        end
        set_line(w, stop_bit);
        tick(div);
        set_line(w, 1'b1);
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        tick(5);
        n_chk++;
        if ({a_data, a_perr, a_ferr, a_valid, a_ovr, a_brk, a_busy}
            !== 14'h0)
            $display("FAIL reset_a: got %h want 0",
                     {a_data, a_perr, a_ferr, a_valid, a_ovr, a_brk,
                      a_busy});
        else n_pass++;
        n_chk++;
        if ({b_data, b_perr, b_ferr, b_valid, b_ovr, b_brk, b_busy}
            !== 14'h0)
            $display("FAIL reset_b: got %h want 0",
                     {b_data, b_perr, b_ferr, b_valid, b_ovr, b_brk,
                      b_busy});
        else n_pass++;
        n_chk++;
        if ({c_data, c_perr, c_ferr, c_valid, c_ovr, c_brk, c_busy}
            !== 14'h0)
            $display("FAIL reset_c: got %h want 0",
                     {c_data, c_perr, c_ferr, c_valid, c_ovr, c_brk,
                      c_busy});
        else n_pass++;
        rst_n = 1'b1;
        tick(5);
    endtask

    task automatic test_glitch;
        set_line(0, 1'b0);
        tick(500);
        n_chk++;
        if (a_busy !== 1'b1)
            $display("FAIL glitch_busy_hi: got %b want 1", a_busy);
        else n_pass++;
        tick(500);
        set_line(0, 1'b1);
        tick(HALF_A + 10);
        n_chk++;
        if ({a_busy, a_valid} !== 2'b00)
            $display("FAIL glitch_idle: got %b want 00",
                     {a_busy, a_valid});
        else n_pass++;
    endtask

    task automatic test_latency;
        int t0;
        int lat;
        a_ready = 1'b1;
        q_a.push_back({8'hA5, 2'b00});
        t0  = cyc;
        lat = -1;
        fork
            send_frame(0, DIV_A, 8'hA5, 1'b0, 1'b0, 1'b1);
            begin
                for (int i = 0; i < 30000; i++) begin
                    @(negedge clk);
                    if (a_valid) begin
                        lat = cyc - t0;
                        break;
                    end
                end
                @(negedge clk);
                n_chk++;
                if (a_valid !== 1'b0)
                    $display("FAIL latency_pop: got %b want 0", a_valid);
                else n_pass++;
            end
        join
        n_chk++;
        if (lat < 24735 || lat > 24741)
            $display("FAIL latency: got %0d want 24738+-3", lat);
        else n_pass++;
        tick(DIV_A);
    endtask

    task automatic test_parity;
        c_ready = 1'b1;
        q_c.push_back({8'h3C, 2'b10});
        send_frame(2, DIV_F, 8'h3C, 1'b1, 1'b1, 1'b1);
        q_c.push_back({8'h3C, 2'b00});
        send_frame(2, DIV_F, 8'h3C, 1'b1, 1'b0, 1'b1);
        tick(DIV_F);
        n_chk++;
        if (c_nbrk !== 0)
            $display("FAIL parity_brk: got %0d want 0", c_nbrk);
        else n_pass++;
    endtask

    task automatic test_ferr_back_to_back;
        int brk0;
        b_ready = 1'b1;
        brk0 = b_nbrk;
        q_b.push_back({8'h81, 2'b01});
        send_frame(1, DIV_F, 8'h81, 1'b0, 1'b0, 1'b0);
        tick(2 * DIV_F);
        n_chk++;
        if (b_nbrk !== brk0)
            $display("FAIL ferr_nobrk: got %0d want %0d", b_nbrk, brk0);
        else n_pass++;
        q_b.push_back({8'h7E, 2'b00});
        send_frame(1, DIV_F, 8'h7E, 1'b0, 1'b0, 1'b1);
        q_b.push_back({8'h99, 2'b00});
        send_frame(1, DIV_F, 8'h99, 1'b0, 1'b0, 1'b1);
        tick(DIV_F);
    endtask

    task automatic test_vote;
        b_ready = 1'b1;
        q_b.push_back({8'hFF, 2'b00});
        set_line(1, 1'b0);
        tick(DIV_F);
        // Isolated one-cycle lows throughout the data bits.
        for (int i = 0; i < 8 * DIV_F; i++) begin
            set_line(1, (i % 3 == 1) ? 1'b0 : 1'b1);
            tick(1);
        end
        set_line(1, 1'b1);
        tick(2 * DIV_F);
    endtask

    task automatic test_overrun;
        int ovr0;
        b_ready = 1'b0;
        ovr0 = b_novr;
        for (int i = 1; i <= 4; i++) begin
            q_b.push_back({8'(i), 2'b00});
            send_frame(1, DIV_F, 8'(i), 1'b0, 1'b0, 1'b1);
        end
        n_chk++;
        if (b_novr - ovr0 !== 0)
            $display("FAIL ovr_early: got %0d want 0", b_novr - ovr0);
        else n_pass++;
        send_frame(1, DIV_F, 8'h05, 1'b0, 1'b0, 1'b1);
        tick(2);
        n_chk++;
        if (b_novr - ovr0 !== 1)
            $display("FAIL ovr_frame5: got %0d want 1", b_novr - ovr0);
        else n_pass++;
        b_ready = 1'b1;
        tick(8);
        n_chk++;
        if ({b_valid, 32'(q_b.size())} !== 33'h0)
            $display("FAIL ovr_drain: got valid %b left %0d want 0 0",
                     b_valid, q_b.size());
        else n_pass++;
    endtask

    task automatic test_break;
        int brk0;
        b_ready = 1'b1;
        brk0 = b_nbrk;
        q_b.push_back({8'h00, 2'b01});
        set_line(1, 1'b0);
        tick(12 * DIV_F);
        n_chk++;
        if (b_nbrk - brk0 !== 1)
            $display("FAIL brk_pulse: got %0d want 1", b_nbrk - brk0);
        else n_pass++;
        set_line(1, 1'b1);
        tick(4);
        n_chk++;
        if (b_busy !== 1'b1)
            $display("FAIL brk_wait: got %b want 1", b_busy);
        else n_pass++;
        tick(HALF_F + 4);
        n_chk++;
        if (b_busy !== 1'b0)
            $display("FAIL brk_release: got %b want 0", b_busy);
        else n_pass++;
        tick(DIV_F);
    endtask

    task automatic test_reset_mid;
        b_ready = 1'b0;
        send_frame(1, DIV_F, 8'h42, 1'b0, 1'b0, 1'b1);
        tick(2);
        n_chk++;
        if (b_valid !== 1'b1)
            $display("FAIL rmid_held: got %b want 1", b_valid);
        else n_pass++;
        set_line(1, 1'b0);
        tick(3 * DIV_F);
        n_chk++;
        if (b_busy !== 1'b1)
            $display("FAIL rmid_busy: got %b want 1", b_busy);
        else n_pass++;
        rst_n = 1'b0;
        tick(1);
        n_chk++;
        if ({b_valid, b_busy} !== 2'b00)
            $display("FAIL rmid_clear: got %b want 00",
                     {b_valid, b_busy});
        else n_pass++;
        set_line(1, 1'b1);
        tick(3);
        rst_n = 1'b1;
        tick(5);
        b_ready = 1'b1;
        tick(2);
        n_chk++;
        if (b_valid !== 1'b0)
            $display("FAIL rmid_empty: got %b want 0", b_valid);
        else n_pass++;
    endtask

    task automatic test_final;
        n_chk++;
        if (q_a.size() + q_b.size() + q_c.size() !== 0)
            $display("FAIL scoreboard_left: got %0d %0d %0d want 0",
                     q_a.size(), q_b.size(), q_c.size());
        else n_pass++;
        n_chk++;
        if (a_nbrk + a_novr + c_novr !== 0)
            $display("FAIL stray_pulses: got %0d %0d %0d want 0",
                     a_nbrk, a_novr, c_novr);
        else n_pass++;
        n_chk++;
        if (b_novr !== 1)
            $display("FAIL ovr_total: got %0d want 1", b_novr);
        else n_pass++;
    endtask

    initial begin
        tick(1);
        test_reset;
        test_glitch;
        test_latency;
        test_parity;
        test_ferr_back_to_back;
        test_vote;
        test_overrun;
        test_break;
        test_reset_mid;
        tick(4);
        test_final;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
